// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package   : cpu_pkg
// Purpose   : Shared ALU opcodes, operand-select encodings and datapath width.
// Revision  : 1.0
// ============================================================================
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_BNE  = 4'b1011;
    localparam logic [3:0] ALU_BLT  = 4'b1100;
    localparam logic [3:0] ALU_BLTU = 4'b1101;
    localparam logic [3:0] ALU_BGE  = 4'b1110;
    localparam logic [3:0] ALU_BGEU = 4'b1111;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module    : fwd_mux
// Purpose   : Per-source operand forwarding selector (EX over MEM over regfile).
// Revision  : 1.0
// ============================================================================
module fwd_mux #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs_addr,
    input  logic [XLEN-1:0]   i_rf_data,
    input  logic              i_ex_valid,
    input  logic              i_ex_reg_write,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rd_addr,
    input  logic [XLEN-1:0]   i_ex_result,
    input  logic              i_mem_reg_write,
    input  logic [REG_AW-1:0] i_mem_rd_addr,
    input  logic [XLEN-1:0]   i_mem_result,
    output logic [XLEN-1:0]   o_data,
    output logic              o_ex_load_hit
);

    logic w_ex_addr_hit;
    logic w_ex_fwd;
    logic w_mem_fwd;

    // x0 is hard-wired zero, so a write aimed at it never matches a source.
    assign w_ex_addr_hit = i_ex_valid && (i_ex_rd_addr != '0) && (i_ex_rd_addr == i_rs_addr);
    assign w_ex_fwd      = w_ex_addr_hit && i_ex_reg_write && !i_ex_mem_read;
    assign w_mem_fwd     = i_mem_reg_write && (i_mem_rd_addr != '0) && (i_mem_rd_addr == i_rs_addr);
    assign o_ex_load_hit = w_ex_addr_hit && i_ex_mem_read;

    always_comb begin
        o_data = i_rf_data;
        if (w_ex_fwd) begin
            o_data = i_ex_result;
        end else if (w_mem_fwd) begin
            o_data = i_mem_result;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module    : id_ex_operand_stage
// Purpose   : ID/EX register feeding the ALU with forwarding and load-use stall.
// Revision  : 1.0
// ============================================================================
module id_ex_operand_stage #(
    parameter int XLEN   = cpu_pkg::XLEN,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_op,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [1:0]        id_a_sel,
    input  logic [1:0]        id_b_sel,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_is_branch,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              flush,
    input  logic              hold,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [3:0]        ALUop,
    output logic [XLEN-1:0]   A,
    output logic [XLEN-1:0]   B,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_is_branch
);

    logic              r_ex_valid;
    logic [3:0]        r_alu_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_store_data;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_is_branch;

    logic [XLEN-1:0]   w_rs1_fwd;
    logic [XLEN-1:0]   w_rs2_fwd;
    logic              w_rs1_ld_hit;
    logic              w_rs2_ld_hit;
    logic              w_rs1_used;
    logic              w_rs2_used;
    logic              w_load_use;
    logic              w_update;
    logic              w_capture;
    logic [XLEN-1:0]   w_a_next;
    logic [XLEN-1:0]   w_b_next;

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .i_rs_addr       (id_rs1_addr),
        .i_rf_data       (id_rs1_data),
        .i_ex_valid      (r_ex_valid),
        .i_ex_reg_write  (r_reg_write),
        .i_ex_mem_read   (r_mem_read),
        .i_ex_rd_addr    (r_rd_addr),
        .i_ex_result     (ex_result),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_rd_addr   (mem_rd_addr),
        .i_mem_result    (mem_result),
        .o_data          (w_rs1_fwd),
        .o_ex_load_hit   (w_rs1_ld_hit)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .i_rs_addr       (id_rs2_addr),
        .i_rf_data       (id_rs2_data),
        .i_ex_valid      (r_ex_valid),
        .i_ex_reg_write  (r_reg_write),
        .i_ex_mem_read   (r_mem_read),
        .i_ex_rd_addr    (r_rd_addr),
        .i_ex_result     (ex_result),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_rd_addr   (mem_rd_addr),
        .i_mem_result    (mem_result),
        .o_data          (w_rs2_fwd),
        .o_ex_load_hit   (w_rs2_ld_hit)
    );

    // Stores and branches consume rs2 even when B is sourced elsewhere.
    assign w_rs1_used = (id_a_sel == cpu_pkg::A_RS1);
    assign w_rs2_used = (id_b_sel == cpu_pkg::B_RS2) || id_mem_write || id_is_branch;
    assign w_load_use = id_valid && ((w_rs1_used && w_rs1_ld_hit) || (w_rs2_used && w_rs2_ld_hit));
    assign stall_id   = w_load_use && !flush && !hold;

    // flush overrides hold; otherwise hold freezes the register.
    assign w_update  = flush || !hold;
    assign w_capture = !flush && !hold && !w_load_use && id_valid;

    always_comb begin
        w_a_next = '0;
        case (id_a_sel)
            cpu_pkg::A_RS1: w_a_next = w_rs1_fwd;
            cpu_pkg::A_PC:  w_a_next = id_pc;
            default:        w_a_next = '0;
        endcase
    end

    always_comb begin
        w_b_next = '0;
        case (id_b_sel)
            cpu_pkg::B_RS2:  w_b_next = w_rs2_fwd;
            cpu_pkg::B_IMM:  w_b_next = id_imm;
            cpu_pkg::B_FOUR: w_b_next = XLEN'(4);
            default:         w_b_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_alu_op     <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_store_data <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_is_branch  <= 1'b0;
        end else if (w_update) begin
            // Any non-capture update loads the all-zero bubble.
            r_ex_valid   <= w_capture;
            r_alu_op     <= w_capture ? id_alu_op    : 4'b0000;
            r_a          <= w_capture ? w_a_next     : '0;
            r_b          <= w_capture ? w_b_next     : '0;
            r_store_data <= w_capture ? w_rs2_fwd    : '0;
            r_rd_addr    <= w_capture ? id_rd_addr   : '0;
            r_reg_write  <= w_capture && id_reg_write;
            r_mem_read   <= w_capture && id_mem_read;
            r_mem_write  <= w_capture && id_mem_write;
            r_is_branch  <= w_capture && id_is_branch;
        end
    end

    assign ex_valid      = r_ex_valid;
    assign ALUop         = r_alu_op;
    assign A             = r_a;
    assign B             = r_b;
    assign ex_store_data = r_store_data;
    assign ex_rd_addr    = r_rd_addr;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_is_branch  = r_is_branch;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module    : tb_id_ex_operand_stage
// Purpose   : Directed scoreboard bench for the ID/EX operand stage.
// Revision  : 1.0
// ============================================================================
module tb_id_ex_operand_stage;

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd, mrd;
        logic [31:0] d1, d2, imm, pc, exr, mres;
        logic [1:0]  as, bs;
        logic        rw, mr, mw, br, mrw, fl, hd;
    } in_t;

    typedef struct {
        string       name;
        logic        stall;
        logic        v;
        logic [3:0]  op;
        logic [31:0] a, b, sd;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
    } exp_t;

    logic        clk, rst_n;
    logic        id_valid, id_reg_write, id_mem_read, id_mem_write, id_is_branch;
    logic [3:0]  id_alu_op;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, mem_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc, ex_result, mem_result;
    logic [1:0]  id_a_sel, id_b_sel;
    logic        mem_reg_write, flush, hold;
    logic        stall_id, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch;
    logic [3:0]  ALUop;
    logic [31:0] A, B, ex_store_data;
    logic [4:0]  ex_rd_addr;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    id_ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_is_branch(id_is_branch),
        .ex_result(ex_result), .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .mem_result(mem_result), .flush(flush), .hold(hold), .stall_id(stall_id),
        .ex_valid(ex_valid), .ALUop(ALUop), .A(A), .B(B), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_is_branch(ex_is_branch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endtask

    function automatic in_t nop();
        in_t t;
        t.v = 0; t.op = 0; t.rs1 = 0; t.rs2 = 0; t.rd = 0; t.mrd = 0;
        t.d1 = 0; t.d2 = 0; t.imm = 0; t.pc = 0; t.exr = 0; t.mres = 0;
        t.as = 0; t.bs = 0; t.rw = 0; t.mr = 0; t.mw = 0; t.br = 0;
        t.mrw = 0; t.fl = 0; t.hd = 0;
        return t;
    endfunction

    function automatic exp_t mk(input string n, input logic st, input logic v,
                                input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] sd, input logic [4:0] rd, input logic [3:0] ctrl);
        exp_t e;
        e.name = n; e.stall = st; e.v = v; e.op = op; e.a = a; e.b = b;
        e.sd = sd; e.rd = rd; e.ctrl = ctrl;
        return e;
    endfunction

    task automatic apply(input in_t t);
        id_valid = t.v; id_alu_op = t.op; id_rs1_addr = t.rs1; id_rs2_addr = t.rs2;
        id_rs1_data = t.d1; id_rs2_data = t.d2; id_imm = t.imm; id_pc = t.pc;
        id_a_sel = t.as; id_b_sel = t.bs; id_rd_addr = t.rd; id_reg_write = t.rw;
        id_mem_read = t.mr; id_mem_write = t.mw; id_is_branch = t.br;
        ex_result = t.exr; mem_rd_addr = t.mrd; mem_reg_write = t.mrw;
        mem_result = t.mres; flush = t.fl; hold = t.hd;
    endtask

    task automatic step(input in_t t, input exp_t e);
        @(negedge clk);
        apply(t);
        exp_q.push_back(e);
    endtask

    // Monitor: stall_id is checked mid-cycle, EX outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".stall_id"}, 32'(stall_id), 32'(e.stall));
                @(posedge clk);
                #1;
                chk({e.name, ".ex_valid"}, 32'(ex_valid), 32'(e.v));
                chk({e.name, ".ALUop"}, 32'(ALUop), 32'(e.op));
                chk({e.name, ".A"}, A, e.a);
                chk({e.name, ".B"}, B, e.b);
                chk({e.name, ".store"}, ex_store_data, e.sd);
                chk({e.name, ".rd"}, 32'(ex_rd_addr), 32'(e.rd));
                chk({e.name, ".ctrl"},
                    32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch}), 32'(e.ctrl));
            end
        end
    end

    initial begin
        in_t t;
        int  waited;
        rst_n = 1'b0;
        apply(nop());
        repeat (2) @(negedge clk);
        chk("reset.ex_valid", 32'(ex_valid), 32'd0);
        chk("reset.A", A, 32'd0);
        chk("reset.stall", 32'(stall_id), 32'd0);
        rst_n = 1'b1;

        // Plain ADD x1+x2 -> x3
        t = nop(); t.v = 1; t.op = 4'b0000; t.rs1 = 1; t.d1 = 5; t.rs2 = 2; t.d2 = 7;
        t.rd = 3; t.rw = 1;
        step(t, mk("add", 0, 1, 4'b0000, 5, 7, 7, 3, 4'b1000));

        // SUB reads x3 produced in EX
        t = nop(); t.v = 1; t.op = 4'b0001; t.rs1 = 3; t.d1 = 0; t.rs2 = 2; t.d2 = 7;
        t.rd = 3; t.rw = 1; t.exr = 32'h10;
        step(t, mk("fwd_ex", 0, 1, 4'b0001, 32'h10, 7, 7, 3, 4'b1000));

        // EX and MEM both target x3: EX wins
        t.mrd = 3; t.mrw = 1; t.mres = 32'h20;
        step(t, mk("ex_over_mem", 0, 1, 4'b0001, 32'h10, 7, 7, 3, 4'b1000));

        // Load to x4
        t = nop(); t.v = 1; t.rs1 = 1; t.d1 = 32'h100; t.bs = 1; t.imm = 8;
        t.rd = 4; t.rw = 1; t.mr = 1;
        step(t, mk("load", 0, 1, 4'b0000, 32'h100, 8, 0, 4, 4'b1100));

        // Dependent on x4 via rs2: one bubble, then MEM forward
        t = nop(); t.v = 1; t.rs1 = 1; t.d1 = 1; t.rs2 = 4; t.d2 = 0; t.rd = 6; t.rw = 1;
        step(t, mk("load_use", 1, 0, 0, 0, 0, 0, 0, 4'b0000));
        t.mrd = 4; t.mrw = 1; t.mres = 32'hABCD;
        step(t, mk("retry_mem", 0, 1, 4'b0000, 1, 32'hABCD, 32'hABCD, 6, 4'b1000));

        // flush with hold and a valid instruction
        t = nop(); t.v = 1; t.op = 4'b0100; t.rs1 = 1; t.d1 = 9; t.rd = 2; t.rw = 1;
        t.fl = 1; t.hd = 1;
        step(t, mk("flush", 0, 0, 0, 0, 0, 0, 0, 4'b0000));

        // Load to x7, then hold for three cycles with a load-use pattern
        t = nop(); t.v = 1; t.rs1 = 1; t.d1 = 32'h11; t.rs2 = 2; t.d2 = 32'h22;
        t.bs = 1; t.imm = 4; t.rd = 7; t.rw = 1; t.mr = 1;
        step(t, mk("load_x7", 0, 1, 4'b0000, 32'h11, 4, 32'h22, 7, 4'b1100));
        for (int i = 0; i < 3; i++) begin
            t = nop(); t.v = 1; t.op = 4'(i + 2); t.rs1 = 7; t.d1 = 32'(i);
            t.rs2 = 7; t.rd = 5'(i + 8); t.rw = 1; t.hd = 1;
            step(t, mk("hold", 0, 1, 4'b0000, 32'h11, 4, 32'h22, 7, 4'b1100));
        end
        t.hd = 0;
        step(t, mk("hold_release_stall", 1, 0, 0, 0, 0, 0, 0, 4'b0000));

        // Load targeting x0, then read x0 with EX/MEM writing x0
        t = nop(); t.v = 1; t.rs1 = 1; t.bs = 1; t.rd = 0; t.rw = 1; t.mr = 1;
        step(t, mk("load_x0", 0, 1, 4'b0000, 0, 0, 0, 0, 4'b1100));
        t = nop(); t.v = 1; t.rs1 = 0; t.rs2 = 0; t.rd = 8; t.rw = 1;
        t.exr = 32'hFFFF; t.mrd = 0; t.mrw = 1; t.mres = 32'hFFFF;
        step(t, mk("x0_no_fwd", 0, 1, 4'b0000, 0, 0, 0, 8, 4'b1000));

        // Branch: B is forwarded rs2 (x8 from EX)
        t = nop(); t.v = 1; t.op = 4'b1010; t.rs1 = 9; t.d1 = 3; t.rs2 = 8; t.d2 = 0;
        t.br = 1; t.exr = 32'h55;
        step(t, mk("branch", 0, 1, 4'b1010, 3, 32'h55, 32'h55, 0, 4'b0001));

        // PC and constant-4 selects
        t = nop(); t.v = 1; t.as = 1; t.pc = 32'h1000; t.bs = 2; t.rs2 = 2; t.d2 = 9;
        t.rd = 1; t.rw = 1;
        step(t, mk("pc_four", 0, 1, 4'b0000, 32'h1000, 4, 9, 1, 4'b1000));

        // Reserved selects give zero
        t = nop(); t.v = 1; t.op = 4'b0011; t.as = 3; t.bs = 3; t.rs1 = 1; t.d1 = 32'h77;
        t.rs2 = 2; t.d2 = 32'h88;
        step(t, mk("reserved_sel", 0, 1, 4'b0011, 0, 0, 32'h88, 0, 4'b0000));

        t = nop();
        step(t, mk("idle", 0, 0, 0, 0, 0, 0, 0, 4'b0000));

        // Load to x4 ahead of the mid-stall reset
        t = nop(); t.v = 1; t.rs1 = 1; t.bs = 1; t.rd = 4; t.rw = 1; t.mr = 1;
        step(t, mk("load_x4", 0, 1, 4'b0000, 0, 0, 0, 4, 4'b1100));

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Store consuming x4 via rs2 stalls; async reset then clears everything
        @(negedge clk);
        t = nop(); t.v = 1; t.rs1 = 1; t.bs = 1; t.imm = 4; t.rs2 = 4; t.mw = 1;
        apply(t);
        #2;
        chk("store_load_use.stall_id", 32'(stall_id), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall.stall_id", 32'(stall_id), 32'd0);
        chk("rst_mid_stall.ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_mid_stall.ctrl",
            32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU; supplies registered ALUop, A and B each cycle.
- Selects operand sources and resolves data hazards: forwarding from the EX and MEM stages, and load-use stall with bubble insertion.
- Honours pipeline flush (taken branch/jump) and downstream hold.

Parameters:
- XLEN, 32, datapath width of A, B, immediate, PC and forwarded results.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_alu_op  in  4  ALU operation code.
- id_rs1_addr, id_rs2_addr  in  REG_AW  source registers.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_pc  in  XLEN  instruction PC.
- id_a_sel  in  2  operand A source: 0=rs1, 1=pc, 2=zero, 3=reserved (treated as zero).
- id_b_sel  in  2  operand B source: 0=rs2, 1=imm, 2=constant 4, 3=reserved (treated as zero).
- id_rd_addr  in  REG_AW  destination register.
- id_reg_write, id_mem_read, id_mem_write, id_is_branch  in  1 each  control bits.
- ex_result  in  XLEN  current ALU output C, for forwarding.
- mem_rd_addr  in  REG_AW  MEM-stage destination.
- mem_reg_write  in  1  MEM-stage write enable.
- mem_result  in  XLEN  MEM-stage writeback value.
- flush  in  1  kill the instruction entering EX.
- hold  in  1  downstream stall; freeze EX register.
- stall_id  out  1  load-use stall request to fetch/decode.
- ex_valid  out  1  EX slot valid.
- ALUop  out  4  to ALU.
- A, B  out  XLEN  to ALU.
- ex_store_data  out  XLEN  forwarded rs2 value for stores.
- ex_rd_addr  out  REG_AW.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch  out  1 each.

Behaviour:
- Clock and reset: all registers on posedge clk; async clear on rst_n low.
- Reset and bubble value for every output: ex_valid=0, ALUop=4'b0000, A=B=ex_store_data=0, ex_rd_addr=0, all control bits 0, stall_id=0.
- Latency: 1 cycle from the ID inputs to the EX outputs.
- rs1_used = id_a_sel==0. rs2_used = (id_b_sel==0) or id_mem_write or id_is_branch.
- Forwarded value per source, in priority order:
  - EX match (ex_valid, ex_reg_write, !ex_mem_read, ex_rd_addr!=0, ex_rd_addr==rs) -> ex_result.
  - else MEM match (mem_reg_write, mem_rd_addr!=0, mem_rd_addr==rs) -> mem_result.
  - else the register-file data.
- Register x0 is never forwarded.
- load_use = id_valid & ex_valid & ex_mem_read & ex_rd_addr!=0 & ((rs1_used & rs1 match) | (rs2_used & rs2 match)).
- stall_id = load_use & ~flush & ~hold (combinational).
- Register update per cycle, highest priority first:
  - flush -> load bubble.
  - hold -> keep all EX registers unchanged.
  - load_use -> load bubble; the ID instruction retries next cycle.
  - id_valid -> load A = mux(id_a_sel), B = mux(id_b_sel), ex_store_data = forwarded rs2, and the control bits.
  - else -> load bubble.
- flush and hold together: flush wins.
- Load followed by a dependent instruction yields exactly one bubble; the second attempt forwards from MEM.
- A branch op (ALUop 1010–1111) passes B = forwarded rs2; the branch target is computed elsewhere.
- Reset asserted mid-stall: outputs clear immediately; stall_id drops.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU opcode localparams: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, BEQ 1010, BNE 1011, BLT 1100, BLTU 1101, BGE 1110, BGEU 1111.
  - Operand-select encodings A_RS1/A_PC/A_ZERO and B_RS2/B_IMM/B_FOUR.
  - XLEN.
- One sub-module, fwd_mux: a combinational per-source forwarding selector, instantiated twice (rs1, rs2).

Test Plan:
- Reset then id_valid=1, ADD, rs1=x1 (data 5), rs2=x2 (data 7), a_sel=0, b_sel=0 -> next cycle ALUop=0000, A=5, B=7, ex_valid=1.
- EX holds ADD to x3; ex_result=0x10; ID instruction SUB reads x3 as rs1, register-file data 0 -> A=0x10. Repeat with EX and MEM both targeting x3 (mem_result=0x20) -> A=0x10 (EX wins).
- EX holds a load to x4; ID instruction uses rs2=x4 -> stall_id=1 for one cycle and the EX outputs become a bubble. Next cycle MEM forwards mem_result=0xABCD -> B=0xABCD, stall_id=0.
- flush=1 with id_valid=1 and hold=1 -> next cycle ex_valid=0, ALUop=0, all control bits 0.
- hold=1 for 3 cycles with changing ID inputs -> A, B and ALUop are unchanged; stall_id=0 despite a load-use pattern.
- Writes targeting x0 in EX and MEM with values 0xFFFF; ID reads x0 with register-file data 0 -> A=0, no stall even when the EX instruction is a load.
